bullet_manager: RTL and testbench
=================================

// Module: bullet_manager
// PURPOSE
//   Owns the player's bullets. Consumes the plane position (planex/planey) from the plane mover and the fire button.
//   Spawns bullets at the plane nose and moves them upward once per move tick.
//   Retires a bullet when it leaves the top of the screen or is reported hit.
//   Drives the renderer and the collision checker with per-slot position and valid vectors.
// PARAMETERS
//   NBUL      4   number of bullet slots (1..8)
//   SPEED     4   pixels a bullet rises per move tick
//   COOLDOWN  16  move ticks between launches
//   NOSE_OFS  14  x offset from planex to the bullet spawn column
//   BUL_H     8   bullet height; spawn y = planey - BUL_H
// PORTS
//   clk         in   1         system clock
//   rst         in   1         asynchronous, active-high reset
//   move        in   1         1-cycle move tick, shared with the plane mover
//   fire        in   1         fire button, level, synchronous to clk
//   planex      in   11        plane x (0..992)
//   planey      in   11        plane y
//   bullet_hit  in   NBUL      per-slot kill request from the collision checker
//   bx          out  NBUL*11   slot i x at [11*i +: 11]
//   by          out  NBUL*11   slot i y at [11*i +: 11]
//   bvalid      out  NBUL      slot i active
//   shots       out  8         launches since reset, saturating at 255
// BEHAVIOUR
//   Reset (async, rst=1): all bvalid=0, bx=by=0, shots=0, cooldown=0, fire_q=0, pending=0.
//     Reset asserted mid-flight clears every bullet immediately.
//   Per slot, two states:
//     IDLE -> ACTIVE on launch.
//     ACTIVE -> IDLE on bullet_hit[i] (any cycle) or on off-top retire (move tick).
//   Move tick, ACTIVE slot not hit: if by >= SPEED then by <= by - SPEED; else bvalid <= 0.
//     No 11-bit underflow is ever visible.
//   bullet_hit[i] on an ACTIVE slot clears bvalid[i] the next clk, regardless of move.
//     Hit wins over move in the same cycle. bx/by hold their last value.
//     bullet_hit on an IDLE slot is ignored.
//   Launch:
//     Evaluated only on a move tick.
//     Requires a fire request, cooldown==0, and at least one slot IDLE at the start of that cycle.
//     The lowest-index IDLE slot gets bx=planex+NOSE_OFS and by=planey-BUL_H, and bvalid=1 one clk after the tick.
//     A slot freed by hit or retire in the same cycle is not reused until a later tick.
//     Launch also sets cooldown=COOLDOWN and increments shots (saturating).
//     The new bullet does not move on its launch tick.
//   Cooldown: decrements by 1 on each move tick while >0. It is not decremented on the launch tick.
//   All slots full: the request is dropped, cooldown is unchanged, and shots is unchanged.
//   Width rules:
//     planex+NOSE_OFS is computed in 11 bits; for planex<=992 it never overflows.
//     planey is always >= BUL_H (bounded by the plane mover).
//   Latency: outputs are registered, one clk from the causing edge.
// CONFIGURATION
//   BULLET_AUTOFIRE_EN defined:
//     Fire request = fire level.
//     Holding fire launches every COOLDOWN+1 ticks while slots are free.
//   BULLET_AUTOFIRE_EN undefined:
//     A rising edge of fire (fire & ~fire_q, sampled every clk) sets pending.
//     Fire request = pending.
//     pending clears on the next move tick whether or not a launch occurs.
//     Holding fire gives exactly one shot.
// TESTING
//   Spawn: rst, planex=496, planey=650, fire pulse, move tick.
//     -> slot0 valid, bx=510, by=642, shots=1.
//     Next tick -> by=638.
//   Retire at top: a bullet at by=3 with SPEED=4, then a move tick.
//     -> bvalid[i]=0 one clk later, by stays 3, no wrap to 2047.
//   Full and cooldown:
//     With COOLDOWN=0, issue 5 fire requests on 5 ticks.
//       -> slots 0..3 valid, 5th dropped, shots=4.
//     Then hit slot1 -> next launch lands in slot1.
//   Hit vs move: bullet_hit[0] and move in the same cycle.
//     -> bvalid[0]=0, by[0] unchanged.
//     A simultaneous fire does not reuse slot0 this tick.
//   Cooldown: fire is held; check each macro setting.
//     With macro: launches on ticks 0, 17, 34.
//     Without macro: a single launch until fire is released and re-pressed.
//   Async reset: assert rst between clk edges with 3 bullets active.
//     -> bvalid=0 and shots=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/bullet_manager.sv
// bullet_manager: player bullet slots that spawn at the plane nose, rise once per move tick, and retire on hit or off-top.
// Optional macro BULLET_AUTOFIRE_EN: held fire relaunches after every cooldown; default is one shot per fire press.
module bullet_manager #(
  parameter int unsigned NBUL     = 4,
  parameter int unsigned SPEED    = 4,
  parameter int unsigned COOLDOWN = 16,
  parameter int unsigned NOSE_OFS = 14,
  parameter int unsigned BUL_H    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move,
  input  logic               fire,
  input  logic [10:0]        planex,
  input  logic [10:0]        planey,
  input  logic [NBUL-1:0]    bullet_hit,
  output logic [NBUL*11-1:0] bx,
  output logic [NBUL*11-1:0] by,
  output logic [NBUL-1:0]    bvalid,
  output logic [7:0]         shots
);
  localparam int unsigned PW = 11;
  localparam int unsigned CW = $clog2(COOLDOWN + 2);

  logic [NBUL-1:0][PW-1:0] bx_q, bx_d, by_q, by_d;
  logic [NBUL-1:0]         bvalid_q, bvalid_d;
  logic [7:0]              shots_q, shots_d;
  logic [CW-1:0]           cool_q, cool_d;
  logic                    fire_req_c;
  logic [NBUL-1:0]         free_sel_c;
  logic                    launch_c;

`ifdef BULLET_AUTOFIRE_EN
  assign fire_req_c = fire;
`else
  logic fire_q, pending_q, pending_d;

  assign fire_req_c = pending_q;
  // A press arms one request; the next move tick consumes it, launched or not
  assign pending_d  = (fire & ~fire_q) | (pending_q & ~move);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      fire_q    <= fire;
      pending_q <= pending_d;
    end
  end
`endif

  // One-hot lowest idle slot; all zeros when every slot is busy
  assign free_sel_c = ~bvalid_q & (bvalid_q + NBUL'(1));
  assign launch_c   = move & fire_req_c & (cool_q == '0) & (|(~bvalid_q));

  always_comb begin
    bx_d     = bx_q;
    by_d     = by_q;
    bvalid_d = bvalid_q;
    shots_d  = shots_q;
    cool_d   = cool_q;
    for (int unsigned i = 0; i < NBUL; i++) begin
      if (bvalid_q[i]) begin
        if (bullet_hit[i]) begin
          bvalid_d[i] = 1'b0;
        end else if (move) begin
          if (by_q[i] >= PW'(SPEED)) by_d[i] = by_q[i] - PW'(SPEED);
          else                       bvalid_d[i] = 1'b0;
        end
      end else if (launch_c && free_sel_c[i]) begin
        bvalid_d[i] = 1'b1;
        bx_d[i]     = planex + PW'(NOSE_OFS);
        by_d[i]     = planey - PW'(BUL_H);
      end
    end
    if (launch_c) begin
      cool_d = CW'(COOLDOWN);
      if (shots_q != 8'hFF) shots_d = shots_q + 8'd1;
    end else if (move && cool_q != '0) begin
      cool_d = cool_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bx_q     <= '0;
      by_q     <= '0;
      bvalid_q <= '0;
      shots_q  <= '0;
      cool_q   <= '0;
    end else begin
      bx_q     <= bx_d;
      by_q     <= by_d;
      bvalid_q <= bvalid_d;
      shots_q  <= shots_d;
      cool_q   <= cool_d;
    end
  end

  assign bx     = bx_q;
  assign by     = by_q;
  assign bvalid = bvalid_q;
  assign shots  = shots_q;
endmodule

// File: tb/tb_bullet_manager.sv
// Testbench for bullet_manager: spawn/hit table, directed corner sequences, and randomized traffic against a reference model.
module tb_bullet_manager;
  localparam int NBUL = 4, SPEED = 4, COOLDOWN = 16, NOSE_OFS = 14, BUL_H = 8;

  logic              clk = 1'b0, rst = 1'b0, move = 1'b0, fire = 1'b0;
  logic [10:0]       planex = '0, planey = '0;
  logic [NBUL-1:0]   bullet_hit = '0;
  logic [NBUL*11-1:0] bx, by;
  logic [NBUL-1:0]   bvalid;
  logic [7:0]        shots;

  int vectors = 0, miscompares = 0;

  bullet_manager #(.NBUL(NBUL), .SPEED(SPEED), .COOLDOWN(COOLDOWN), .NOSE_OFS(NOSE_OFS), .BUL_H(BUL_H)) dut (
    .clk(clk), .rst(rst), .move(move), .fire(fire), .planex(planex), .planey(planey),
    .bullet_hit(bullet_hit), .bx(bx), .by(by), .bvalid(bvalid), .shots(shots)
  );

  always #5 clk = ~clk;

  // Reference model state, kept as plain integers
  int m_v[NBUL], m_x[NBUL], m_y[NBUL];
  int m_shots, m_cool;
  bit m_pend, m_fprev;

  function automatic void model_reset();
    for (int i = 0; i < NBUL; i++) begin m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; end
    m_shots = 0; m_cool = 0; m_pend = 1'b0; m_fprev = 1'b0;
  endfunction

  function automatic void model_step(input bit mv, input bit fr, input logic [NBUL-1:0] h, input int px, input int py);
    bit req;
    int first_free;
    bit launch;
`ifdef BULLET_AUTOFIRE_EN
    req = fr;
`else
    req = m_pend;
`endif
    first_free = -1;
    for (int i = 0; i < NBUL; i++) if (m_v[i] == 0 && first_free < 0) first_free = i;
    launch = mv && req && m_cool == 0 && first_free >= 0;
    for (int i = 0; i < NBUL; i++) begin
      if (m_v[i] != 0) begin
        if (h[i]) m_v[i] = 0;
        else if (mv) begin
          if (m_y[i] >= SPEED) m_y[i] = m_y[i] - SPEED;
          else m_v[i] = 0;
        end
      end
    end
    if (launch) begin
      m_v[first_free] = 1;
      m_x[first_free] = (px + NOSE_OFS) % 2048;
      m_y[first_free] = py - BUL_H;
      m_cool = COOLDOWN;
      m_shots = (m_shots < 255) ? m_shots + 1 : 255;
    end else if (mv && m_cool > 0) begin
      m_cool = m_cool - 1;
    end
    m_pend = (fr && !m_fprev) || (m_pend && !mv);
    m_fprev = fr;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string name);
    logic [NBUL*11-1:0] ex, ey;
    logic [NBUL-1:0] ev;
    for (int i = 0; i < NBUL; i++) begin
      ex[11*i +: 11] = 11'(m_x[i]);
      ey[11*i +: 11] = 11'(m_y[i]);
      ev[i] = (m_v[i] != 0);
    end
    check({name, ".bvalid"}, 64'(bvalid), 64'(ev));
    check({name, ".shots"}, 64'(shots), 64'(m_shots));
    check({name, ".bx"}, 64'(bx), 64'(ex));
    check({name, ".by"}, 64'(by), 64'(ey));
  endtask

  task automatic tick(input bit mv, input bit fr, input logic [NBUL-1:0] h, input string name);
    @(negedge clk);
    move = mv; fire = fr; bullet_hit = h;
    @(posedge clk);
    model_step(mv, fr, h, int'(planex), int'(planey));
    #1 compare_model(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    move = 1'b0; fire = 1'b0; bullet_hit = '0; rst = 1'b1;
    #1 model_reset();
    compare_model("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit mv; bit fr; logic [3:0] hit;
    logic [3:0] e_valid; int e_bx0; int e_by0; int e_shots;
  } vec_t;

  vec_t tbl[9];
  int   got_ticks[$];
  int   exp_ticks[$];

  initial begin
    logic [7:0] prev;
    bit fr;
    // Spawn, move, hit-vs-idle table (planex=496, planey=650)
    tbl[0] = '{0, 1, 4'h0, 4'h0, 0,   0,   0};
    tbl[1] = '{1, 1, 4'h0, 4'h1, 510, 642, 1};
    tbl[2] = '{0, 0, 4'h0, 4'h1, 510, 642, 1};
    tbl[3] = '{1, 0, 4'h0, 4'h1, 510, 638, 1};
    tbl[4] = '{1, 1, 4'h0, 4'h1, 510, 634, 1};
    tbl[5] = '{0, 0, 4'h0, 4'h1, 510, 634, 1};
    tbl[6] = '{1, 0, 4'h0, 4'h1, 510, 630, 1};
    tbl[7] = '{0, 0, 4'h1, 4'h0, 510, 630, 1};
    tbl[8] = '{1, 0, 4'h1, 4'h0, 510, 630, 1};

    model_reset();
    rst = 1'b1;
    #1;
    compare_model("por");
    planex = 11'd496; planey = 11'd650;
    do_reset();
    for (int r = 0; r < 9; r++) begin
      tick(tbl[r].mv, tbl[r].fr, tbl[r].hit, $sformatf("tbl%0d", r));
      check($sformatf("tbl%0d.bvalid", r), 64'(bvalid), 64'(tbl[r].e_valid));
      check($sformatf("tbl%0d.bx0", r), 64'(bx[10:0]), 64'(tbl[r].e_bx0));
      check($sformatf("tbl%0d.by0", r), 64'(by[10:0]), 64'(tbl[r].e_by0));
      check($sformatf("tbl%0d.shots", r), 64'(shots), 64'(tbl[r].e_shots));
    end

    // Retire at the top: y 11 -> 7 -> 3 -> retired with y held at 3
    planey = 11'd19;
    do_reset();
    tick(0, 1, '0, "top_press");
    tick(1, 1, '0, "top_launch");
    tick(1, 0, '0, "top_m1");
    tick(1, 0, '0, "top_m2");
    check("top_by3", 64'(by[10:0]), 64'd3);
    tick(1, 0, '0, "top_retire");
    check("top_valid", 64'(bvalid[0]), 64'd0);
    check("top_by_hold", 64'(by[10:0]), 64'd3);

    // Fill all slots, drop the fifth request, then refill a hit slot
    planex = 11'd300; planey = 11'd1000;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick(0, 1, '0, "full_press");
      tick(1, 1, '0, "full_tick");
      for (int j = 0; j < COOLDOWN; j++) tick(1, 0, '0, "full_cool");
    end
    check("full_valid", 64'(bvalid), 64'hF);
    check("full_shots", 64'(shots), 64'd4);
    tick(0, 0, 4'b0010, "full_hit1");
    check("full_hit_valid", 64'(bvalid), 64'hD);
    planex = 11'd100;
    tick(0, 1, '0, "refill_press");
    tick(1, 1, '0, "refill_tick");
    check("refill_valid", 64'(bvalid), 64'hF);
    check("refill_bx1", 64'(bx[21:11]), 64'd114);
    check("refill_by1", 64'(by[21:11]), 64'd992);
    check("refill_shots", 64'(shots), 64'd5);

    // Async reset mid-cycle with three bullets live
    tick(0, 0, 4'b1000, "ar_hit3");
    check("ar_pre_valid", 64'(bvalid), 64'h7);
    @(negedge clk);
    move = 1'b0; fire = 1'b0; bullet_hit = '0;
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 64'(bvalid), 64'h0);
    check("ar_shots", 64'(shots), 64'd0);
    check("ar_by", 64'(by), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Hit and move together; a same-tick launch must skip the slot just freed
    planex = 11'd496; planey = 11'd650;
    do_reset();
    tick(0, 1, '0, "hm_press");
    tick(1, 1, '0, "hm_launch");
    for (int j = 0; j < COOLDOWN; j++) tick(1, 0, '0, "hm_cool");
    tick(0, 1, '0, "hm_press2");
    tick(1, 1, 4'b0001, "hm_tick");
    check("hm_valid", 64'(bvalid), 64'h2);
    check("hm_by0", 64'(by[10:0]), 64'd578);
    check("hm_by1", 64'(by[21:11]), 64'd642);
    check("hm_bx1", 64'(bx[21:11]), 64'd510);

    // Fire held across 40 ticks, then released and pressed again
    do_reset();
    tick(0, 1, '0, "cd_press");
    for (int t = 0; t < 40; t++) begin
      prev = shots;
      tick(1, 1, '0, "cd_hold");
      if (shots != prev) got_ticks.push_back(t);
    end
`ifdef BULLET_AUTOFIRE_EN
    exp_ticks = '{0, 17, 34};
`else
    exp_ticks = '{0};
`endif
    check("cd_count", 64'(got_ticks.size()), 64'(exp_ticks.size()));
    for (int i = 0; i < exp_ticks.size() && i < got_ticks.size(); i++)
      check($sformatf("cd_tick%0d", i), 64'(got_ticks[i]), 64'(exp_ticks[i]));
    tick(0, 0, '0, "cd_release");
    tick(0, 1, '0, "cd_repress");
    tick(1, 1, '0, "cd_relaunch");
`ifdef BULLET_AUTOFIRE_EN
    check("cd_shots", 64'(shots), 64'd3);
`else
    check("cd_shots", 64'(shots), 64'd2);
`endif

    // Randomized traffic against the model
    do_reset();
    fr = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      planex = 11'($urandom_range(0, 992));
      planey = 11'($urandom_range(BUL_H, 1023));
      if ($urandom_range(0, 3) == 0) fr = ~fr;
      tick($urandom_range(0, 2) == 0, fr,
           ($urandom_range(0, 7) == 0) ? NBUL'($urandom) : '0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
